irrigation_sequencer: RTL

Timed cycle controller for the irrigation system. Replaces free-running valve decoding with a sequenced cycle: fill tank → wait ready → drip or sprinkler irrigation (optional agrochemical dosing) → line cleaning → refill. Counts durations in seconds from the 1 Hz enable and exports its 3-bit state and a BCD countdown for the 7-segment display path. Sits between the level/irrigation decision logic and the valve/indicator outputs.

---
 rtl/irrigation_sequencer_pkg.sv | 18 +
 rtl/irrigation_sequencer_contador.sv | 37 +++
 rtl/irrigation_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/irrigation_sequencer_pkg.sv
// irrigacao_pkg: shared state codes, BCD digit width and constant BCD conversion
package irrigacao_pkg;
    localparam int DW = 4;

    typedef enum logic [2:0] {
        ENCHENDO    = 3'b000,
        CHEIO       = 3'b001,
        GOTEJAMENTO = 3'b010,
        ASPERSAO    = 3'b011,
        LIMPEZA     = 3'b100,
        ERRO        = 3'b101
    } estado_t;

    // elaboration-time only: turns a 0..99 parameter into {tens, units}
    function automatic logic [2*DW-1:0] to_bcd(input int v);
        return {DW'(v / 10), DW'(v % 10)};
    endfunction
endpackage

// File: rtl/irrigation_sequencer_contador.sv
// contador_bcd_regressivo: 2-digit BCD down counter with load, tick enable and count==1 flag
// Ports: clk, reset (async active-low), load, tick, ld_dez/ld_uni (load value),
//        dez/uni (current digits), um (count is 1)
module contador_bcd_regressivo
    import irrigacao_pkg::*;
#(
    parameter logic [2*DW-1:0] INIT = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          tick,
    input  logic [DW-1:0] ld_dez,
    input  logic [DW-1:0] ld_uni,
    output logic [DW-1:0] dez,
    output logic [DW-1:0] uni,
    output logic          um
);
    assign um = {dez, uni} == 8'h01;

    // load beats tick; holding at 1 (and at 0 for untimed states) means it never wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {dez, uni} <= INIT;
        end else if (load) begin
            dez <= ld_dez;
            uni <= ld_uni;
        end else if (tick && !um && {dez, uni} != '0) begin
            if (uni == '0) begin
                uni <= DW'(9);
                dez <= dez - DW'(1);
            end else begin
                uni <= uni - DW'(1);
            end
        end
    end
endmodule

// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer: timed fill / irrigate / clean cycle controller with BCD countdown
// Ports: clk, reset (async active-low), tick (1 Hz enable), cheio/vazio (level),
//        erro_nivel (sensor fault), req_got/req_asp (demands), agro (dosing request),
//        clr_erro (error ack); outputs state code, ve/vs/bs/agro_out/alarme, dez/uni countdown
module irrigation_sequencer
    import irrigacao_pkg::*;
#(
    parameter int T_FILL_MAX = 60,
    parameter int T_DRIP     = 30,
    parameter int T_SPRAY    = 20,
    parameter int T_AGRO     = 5,
    parameter int T_CLEAN    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          cheio,
    input  logic          vazio,
    input  logic          erro_nivel,
    input  logic          req_got,
    input  logic          req_asp,
    input  logic          agro,
    input  logic          clr_erro,
    output logic [2:0]    state,
    output logic          ve,
    output logic          vs,
    output logic          bs,
    output logic          agro_out,
    output logic          alarme,
    output logic [DW-1:0] dez,
    output logic [DW-1:0] uni
);
    localparam logic [2*DW-1:0] B_FILL  = to_bcd(T_FILL_MAX);
    localparam logic [2*DW-1:0] B_DRIP  = to_bcd(T_DRIP);
    localparam logic [2*DW-1:0] B_SPRAY = to_bcd(T_SPRAY);
    localparam logic [2*DW-1:0] B_CLEAN = to_bcd(T_CLEAN);
    localparam logic [2*DW-1:0] B_AGRO  = to_bcd(T_SPRAY - T_AGRO);

    estado_t         st, nxt;
    logic [2*DW-1:0] ld_val;
    logic [DW-1:0]   cd, cu;
    logic            um, agro_q, fim, timed;

    assign fim = tick && um;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= ENCHENDO;
            agro_q <= 1'b0;
        end else begin
            st     <= nxt;
            agro_q <= agro;
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            ENCHENDO:    nxt = erro_nivel ? ERRO : cheio ? CHEIO : fim ? ERRO : ENCHENDO;
            CHEIO:       nxt = erro_nivel ? ERRO : vazio ? ENCHENDO : req_asp ? ASPERSAO :
                               req_got ? GOTEJAMENTO : CHEIO;
            GOTEJAMENTO,
            ASPERSAO:    nxt = erro_nivel ? ERRO : (vazio || fim) ? LIMPEZA : st;
            LIMPEZA:     nxt = erro_nivel ? ERRO : fim ? ENCHENDO : LIMPEZA;
            ERRO:        nxt = (clr_erro && !erro_nivel) ? ENCHENDO : ERRO;
            default:     nxt = ERRO;
        endcase
    end

    // every state change reloads the counter with the duration of the state being entered
    always_comb begin
        ld_val = nxt == ENCHENDO    ? B_FILL  :
                 nxt == GOTEJAMENTO ? B_DRIP  :
                 nxt == ASPERSAO    ? B_SPRAY :
                 nxt == LIMPEZA     ? B_CLEAN : '0;
    end

    contador_bcd_regressivo #(.INIT(B_FILL)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (nxt != st),
        .tick   (tick),
        .ld_dez (ld_val[2*DW-1:DW]),
        .ld_uni (ld_val[DW-1:0]),
        .dez    (cd),
        .uni    (cu),
        .um     (um)
    );

    assign timed    = st == ENCHENDO || st == GOTEJAMENTO || st == ASPERSAO || st == LIMPEZA;
    assign state    = st;
    assign ve       = st == ENCHENDO;
    assign vs       = st == GOTEJAMENTO || st == LIMPEZA;
    assign bs       = st == ASPERSAO;
    assign alarme   = st == ERRO;
    // BCD digits order the same as binary, so the dosing window is a plain packed compare
    assign agro_out = st == ASPERSAO && agro_q && {cd, cu} > B_AGRO;
    assign dez      = timed ? cd : '0;
    assign uni      = timed ? cu : '0;
endmodule
